// File: rtl/ram_arbiter_pkg.sv
// Shared constants and owner encodings for the fetch/data single-port RAM arbiter.
// The owner encoding names which requester the next-cycle RAM read data belongs to.
package ram_arbiter_pkg;

    localparam int XLEN_WIDTH = 32;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IF   = 2'd1,
        OWN_D    = 2'd2
    } owner_e;

    // A store never produces read data, so only fetches and loads claim the response slot.
    function automatic owner_e owner_next(input logic if_gnt, input logic d_gnt, input logic d_we);
        owner_e w_own;
        w_own = OWN_NONE;
        if (if_gnt) begin
            w_own = OWN_IF;
        end else if (d_gnt && !d_we) begin
            w_own = OWN_D;
        end
        return w_own;
    endfunction

endpackage

// File: rtl/ram_arbiter_dff.sv
// Generic resettable register with a parameterised width and reset value.
module ram_arbiter_dff #(
    parameter int               WIDTH   = 1,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_q;

    // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_q <= RST_VAL;
        end else begin
            r_q <= i_d;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/ram_arbiter.sv
// Arbitrates a fetch port and a data port onto one single-port RAM: data wins by default,
// fetch wins after STARVE_MAX consecutive losses; read data returns one cycle after the grant.
module ram_arbiter
    import ram_arbiter_pkg::*;
#(
    parameter int XLEN       = XLEN_WIDTH,
    parameter int STARVE_MAX = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            if_req,
    input  logic [XLEN-1:0] if_addr,
    input  logic            if_kill,
    output logic            if_gnt,
    output logic            if_rvalid,
    output logic [XLEN-1:0] if_rdata,
    input  logic            d_req,
    input  logic            d_we,
    input  logic [XLEN-1:0] d_addr,
    input  logic [XLEN-1:0] d_wdata,
    output logic            d_gnt,
    output logic            d_rvalid,
    output logic [XLEN-1:0] d_rdata,
    output logic            ram_en,
    output logic            ram_we,
    output logic [XLEN-1:0] ram_addr,
    output logic [XLEN-1:0] ram_wdata,
    input  logic [XLEN-1:0] ram_rdata,
    output logic            pause_signal
);

    localparam int              CNT_W      = $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

    logic [CNT_W-1:0] r_starve_cnt;
    logic             r_if_dropped;
    logic [1:0]       w_owner_d;
    logic [1:0]       w_owner_q;
    owner_e           w_owner;
    logic             w_starved;
    logic             w_if_wins;
    logic             w_if_resp;
    logic             w_d_resp;

    // Grants are masked while reset is asserted so the RAM stays idle even if requests are held.
    assign w_starved = (r_starve_cnt == STARVE_LIM);
    assign w_if_wins = if_req & w_starved;
    assign if_gnt    = rst & if_req & (w_if_wins | ~d_req);
    assign d_gnt     = rst & d_req & ~w_if_wins;

    assign pause_signal = (if_req & ~if_gnt) | (d_req & ~d_gnt);

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        ram_en    = 1'b0;
        ram_we    = 1'b0;
        ram_addr  = '0;
        ram_wdata = '0;
        if (if_gnt) begin
            ram_en   = 1'b1;
            ram_addr = if_addr;
        end else if (d_gnt) begin
            ram_en    = 1'b1;
            ram_we    = d_we;
            ram_addr  = d_addr;
            ram_wdata = d_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_starve_cnt <= '0;
        end else if (!if_req || if_gnt) begin
            r_starve_cnt <= '0;
        end else if (!w_starved) begin
            r_starve_cnt <= r_starve_cnt + 1'b1;
        end
    end

    // A fetch killed in its own grant cycle still occupies the RAM, but its data is discarded.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_if_dropped <= 1'b0;
        end else begin
            r_if_dropped <= if_gnt & if_kill;
        end
    end

    assign w_owner_d = owner_next(if_gnt, d_gnt, d_we);

    ram_arbiter_dff #(
        .WIDTH   (2),
        .RST_VAL (OWN_NONE)
    ) u_owner_dff (
        .clk (clk),
        .rst (rst),
        .i_d (w_owner_d),
        .o_q (w_owner_q)
    );

    assign w_owner   = owner_e'(w_owner_q);
    assign w_if_resp = (w_owner == OWN_IF) & ~r_if_dropped & ~if_kill;
    assign w_d_resp  = (w_owner == OWN_D);

    assign if_rvalid = w_if_resp;
    assign if_rdata  = w_if_resp ? ram_rdata : '0;
    assign d_rvalid  = w_d_resp;
    assign d_rdata   = w_d_resp ? ram_rdata : '0;

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter: a behavioural single-port RAM with one-cycle read latency
// sits behind the arbiter; all expectations are hand-computed constants.
module tb_ram_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req, if_kill, d_req, d_we;
    logic [31:0] if_addr, d_addr, d_wdata;
    logic        if_gnt, if_rvalid, d_gnt, d_rvalid;
    logic [31:0] if_rdata, d_rdata;
    logic        ram_en, ram_we;
    logic [31:0] ram_addr, ram_wdata;
    logic [31:0] ram_rdata = '0;
    logic        pause_signal;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    ram_arbiter #(.XLEN(32), .STARVE_MAX(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .if_req       (if_req),
        .if_addr      (if_addr),
        .if_kill      (if_kill),
        .if_gnt       (if_gnt),
        .if_rvalid    (if_rvalid),
        .if_rdata     (if_rdata),
        .d_req        (d_req),
        .d_we         (d_we),
        .d_addr       (d_addr),
        .d_wdata      (d_wdata),
        .d_gnt        (d_gnt),
        .d_rvalid     (d_rvalid),
        .d_rdata      (d_rdata),
        .ram_en       (ram_en),
        .ram_we       (ram_we),
        .ram_addr     (ram_addr),
        .ram_wdata    (ram_wdata),
        .ram_rdata    (ram_rdata),
        .pause_signal (pause_signal)
    );

    // RAM model: unwritten word i reads as 0x1000_0000 + i (word index = addr[9:2]).
    logic [31:0]  mem [256];
    logic [255:0] wr_mask = '0;

    always @(posedge clk) begin
        if (ram_en) begin
            if (ram_we) begin
                mem[ram_addr[9:2]]     <= ram_wdata;
                wr_mask[ram_addr[9:2]] <= 1'b1;
            end else begin
                ram_rdata <= wr_mask[ram_addr[9:2]] ? mem[ram_addr[9:2]]
                                                    : (32'h1000_0000 + {24'd0, ram_addr[9:2]});
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, act, exp);
        end
    endtask

    task automatic idle();
        if_req  = 1'b0; if_addr = '0; if_kill = 1'b0;
        d_req   = 1'b0; d_we    = 1'b0; d_addr = '0; d_wdata = '0;
    endtask

    // Inputs change just after the falling edge; checks run 1 time unit later.
    task automatic next_cycle();
        @(negedge clk);
    endtask

    initial begin
        idle();
        rst = 1'b0;

        // Reset state
        next_cycle(); #1;
        check("rst_if_gnt",    {31'd0, if_gnt},    32'd0);
        check("rst_d_gnt",     {31'd0, d_gnt},     32'd0);
        check("rst_ram_en",    {31'd0, ram_en},    32'd0);
        check("rst_if_rvalid", {31'd0, if_rvalid}, 32'd0);
        check("rst_d_rvalid",  {31'd0, d_rvalid},  32'd0);
        check("rst_if_rdata",  if_rdata,           32'd0);
        check("rst_d_rdata",   d_rdata,            32'd0);
        next_cycle();
        rst = 1'b1;

        // Fetch-only stream 0x0, 0x4, 0x8 with no bubbles
        next_cycle(); if_req = 1'b1; if_addr = 32'h0; #1;
        check("fs0_if_gnt",  {31'd0, if_gnt},  32'd1);
        check("fs0_ram_en",  {31'd0, ram_en},  32'd1);
        check("fs0_ram_we",  {31'd0, ram_we},  32'd0);
        check("fs0_pause",   {31'd0, pause_signal}, 32'd0);
        next_cycle(); if_addr = 32'h4; #1;
        check("fs1_if_gnt",  {31'd0, if_gnt},    32'd1);
        check("fs1_ram_addr", ram_addr,          32'h4);
        check("fs1_rvalid",  {31'd0, if_rvalid}, 32'd1);
        check("fs1_rdata",   if_rdata,           32'h1000_0000);
        next_cycle(); if_addr = 32'h8; #1;
        check("fs2_rvalid",  {31'd0, if_rvalid}, 32'd1);
        check("fs2_rdata",   if_rdata,           32'h1000_0001);
        next_cycle(); idle(); #1;
        check("fs3_if_gnt",  {31'd0, if_gnt},    32'd0);
        check("fs3_rvalid",  {31'd0, if_rvalid}, 32'd1);
        check("fs3_rdata",   if_rdata,           32'h1000_0002);
        next_cycle(); #1;
        check("fs4_rvalid",  {31'd0, if_rvalid}, 32'd0);

        // Store 0xDEADBEEF to 0x100, then load it back
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h100; d_wdata = 32'hDEAD_BEEF; #1;
        check("st_d_gnt",     {31'd0, d_gnt},  32'd1);
        check("st_ram_we",    {31'd0, ram_we}, 32'd1);
        check("st_ram_wdata", ram_wdata,       32'hDEAD_BEEF);
        next_cycle(); d_we = 1'b0; d_wdata = '0; #1;
        check("ld_d_gnt",     {31'd0, d_gnt},    32'd1);
        check("ld_ram_we",    {31'd0, ram_we},   32'd0);
        check("st_no_rvalid", {31'd0, d_rvalid}, 32'd0);
        next_cycle(); idle(); #1;
        check("ld_d_rvalid",  {31'd0, d_rvalid},  32'd1);
        check("ld_d_rdata",   d_rdata,            32'hDEAD_BEEF);
        check("ld_if_rvalid", {31'd0, if_rvalid}, 32'd0);

        // Both requesters held high: D D D D F D D D D F
        for (int k = 0; k < 10; k++) begin
            next_cycle();
            if_req = 1'b1; if_addr = 32'h8;
            d_req  = 1'b1; d_we = 1'b0; d_addr = 32'h0;
            #1;
            check($sformatf("starve%0d_if_gnt", k), {31'd0, if_gnt}, {31'd0, (k == 4 || k == 9)});
            check($sformatf("starve%0d_d_gnt", k),  {31'd0, d_gnt},  {31'd0, !(k == 4 || k == 9)});
            check($sformatf("starve%0d_pause", k),  {31'd0, pause_signal}, 32'd1);
            check($sformatf("starve%0d_if_rv", k),  {31'd0, if_rvalid}, {31'd0, (k == 5)});
        end
        next_cycle(); idle();
        next_cycle();

        // Kill in the response cycle; a data load granted that cycle still returns
        if_req = 1'b1; if_addr = 32'h4; #1;
        check("kr_if_gnt", {31'd0, if_gnt}, 32'd1);
        next_cycle(); idle(); if_kill = 1'b1; d_req = 1'b1; d_addr = 32'h8; #1;
        check("kr_d_gnt",     {31'd0, d_gnt},     32'd1);
        check("kr_if_rvalid", {31'd0, if_rvalid}, 32'd0);
        check("kr_if_rdata",  if_rdata,           32'd0);
        next_cycle(); idle(); #1;
        check("kr_d_rvalid",  {31'd0, d_rvalid},  32'd1);
        check("kr_d_rdata",   d_rdata,            32'h1000_0002);

        // Kill in the grant cycle: grant proceeds, response still dropped
        next_cycle(); if_req = 1'b1; if_addr = 32'h0; if_kill = 1'b1; #1;
        check("kg_if_gnt", {31'd0, if_gnt}, 32'd1);
        next_cycle(); idle(); #1;
        check("kg_if_rvalid", {31'd0, if_rvalid}, 32'd0);
        check("kg_if_rdata",  if_rdata,           32'd0);

        // Reset during an in-flight load, with the starvation counter non-zero
        next_cycle();
        if_req = 1'b1; if_addr = 32'h0; d_req = 1'b1; d_addr = 32'h4; #1;
        check("rf0_d_gnt", {31'd0, d_gnt}, 32'd1);
        next_cycle(); #1;
        check("rf1_d_gnt", {31'd0, d_gnt}, 32'd1);
        next_cycle(); rst = 1'b0; #1;
        check("rf_d_rvalid",  {31'd0, d_rvalid}, 32'd0);
        check("rf_d_rdata",   d_rdata,           32'd0);
        check("rf_if_gnt",    {31'd0, if_gnt},   32'd0);
        check("rf_d_gnt",     {31'd0, d_gnt},    32'd0);
        check("rf_ram_en",    {31'd0, ram_en},   32'd0);
        check("rf_ram_we",    {31'd0, ram_we},   32'd0);
        check("rf_counter",   {29'd0, dut.r_starve_cnt}, 32'd0);
        next_cycle(); idle(); rst = 1'b1; #1;
        check("rel_d_rvalid",  {31'd0, d_rvalid},  32'd0);
        check("rel_if_rvalid", {31'd0, if_rvalid}, 32'd0);
        check("rel_counter",   {29'd0, dut.r_starve_cnt}, 32'd0);
        next_cycle(); #1;
        check("rel2_d_rvalid", {31'd0, d_rvalid}, 32'd0);
        check("rel2_ram_en",   {31'd0, ram_en},   32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
